// File: rtl/trackball_quad_emu.sv
// trackball_quad_emu: signed X/Y motion deltas to rate-limited quadrature A/B pins; define TRACKBALL_QUAD_EMU_SAT_EN for saturating accumulators
module trackball_quad_emu #(
  parameter int STEP_DIV = 16,
  parameter int ACC_W = 10,
  parameter logic [1:0] DIR_INV = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       delta_valid,
  output logic       delta_ready,
  input  logic [7:0] delta_x,
  input  logic [7:0] delta_y,
  output logic [1:0] quad_a,
  output logic [1:0] quad_b,
  output logic       busy
);
`ifdef TRACKBALL_QUAD_EMU_SAT_EN
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] MAXV = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {3'b111, {(ACC_W-1){1'b0}}};
`else
  localparam int SW = ACC_W;
`endif
  logic [15:0] div_q, div_d;
  logic        stb, accept, delta_ready_q, busy_q;
  logic [1:0]  nz;
  assign stb = div_q == 16'(STEP_DIV - 1);
  assign div_d = stb ? '0 : div_q + 16'd1;
  assign accept = delta_valid && delta_ready_q;
  for (genvar i = 0; i < 2; i++) begin : g_axis
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [SW-1:0]    sum, adj;
    logic signed [7:0]       dl;
    logic [1:0]              ph_q, ph_d;
    logic                    pos, neg;
    always_comb begin
      dl = accept ? (i == 0 ? delta_x : delta_y) : 8'sd0;
      pos = stb && !acc_q[ACC_W-1] && acc_q != '0;
      neg = stb && acc_q[ACC_W-1];
      adj = pos ? '1 : neg ? SW'(1) : '0;
      sum = SW'(acc_q) + SW'(dl) + adj;
`ifdef TRACKBALL_QUAD_EMU_SAT_EN
      acc_d = sum > MAXV ? MAXV[ACC_W-1:0] : sum < MINV ? MINV[ACC_W-1:0] : sum[ACC_W-1:0];
`else
      acc_d = sum;
`endif
      // inversion flips only the pin sequence direction, never the accumulator drain
      ph_d = (pos || neg) ? ph_q + ((pos ^ DIR_INV[i]) ? 2'd1 : 2'd3) : ph_q;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= '0;
        ph_q  <= '0;
      end else begin
        acc_q <= acc_d;
        ph_q  <= ph_d;
      end
    end
    assign nz[i] = acc_d != '0;
    assign quad_a[i] = ph_q[1];
    assign quad_b[i] = ph_q[1] ^ ph_q[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      delta_ready_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      div_q         <= div_d;
      delta_ready_q <= 1'b1;
      busy_q        <= |nz;
    end
  end
  assign delta_ready = delta_ready_q;
  assign busy = busy_q;
endmodule

// File: doc/trackball_quad_emu.md
Name: trackball_quad_emu

Overview:
- Upstream stage of the LETA trackball controller.
- Converts signed per-axis motion deltas from the host-side input adapter into quadrature A/B pin waveforms. These are the waveforms the LETA counters expect from a physical trackball.
- Two axes (X, Y). Output pins drive the LETA quadrature inputs directly.
- Stepping is rate-limited so the downstream counter, clocked at 8H, never misses a transition.

Parameters:
- STEP_DIV, 16, clocks between step opportunities; legal range 2..65535.
- ACC_W, 10, width of each signed per-axis pending accumulator; range -2^(ACC_W-1) .. 2^(ACC_W-1)-1.
- DIR_INV, 2'b00, bit0 inverts X direction, bit1 inverts Y direction.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- delta_valid  input  1  delta_x/delta_y present this cycle.
- delta_ready  output  1  block accepts a delta this cycle.
- delta_x  input  8  signed X motion, two's complement, -128..127.
- delta_y  input  8  signed Y motion, two's complement, -128..127.
- quad_a  output  2  quadrature A; [0]=X, [1]=Y.
- quad_b  output  2  quadrature B; [0]=X, [1]=Y.
- busy  output  1  high while either accumulator is nonzero.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state updates on posedge clk.
- Reset (rst=1 at a posedge):
  - Both accumulators become 0; both phases become 0 (quad_a=quad_b=2'b00).
  - Divider becomes 0; delta_ready becomes 0; busy becomes 0.
  - Reset mid-stepping discards all pending motion immediately.
- delta_ready:
  - Registered; 0 during reset, 1 from the first cycle after rst deasserts.
  - No backpressure afterwards; saturation handles overflow.
- Acceptance: a delta is accepted on a posedge where delta_valid && delta_ready. Each delta is sign-extended to ACC_W and added to its axis accumulator.
- Divider:
  - Counts 0..STEP_DIV-1 and wraps to 0.
  - step_stb is asserted in the cycle where divider == STEP_DIV-1.
- Per-axis step on step_stb:
  - acc>0: phase advances +1 (mod 4), acc decrements by 1.
  - acc<0: phase advances -1 (mod 4), acc increments by 1.
  - acc==0: no change.
- Phase-to-pins (A,B) per phase:
  - 0=(0,0), 1=(0,1), 2=(1,1), 3=(1,0).
  - Exactly one pin toggles per step.
  - DIR_INV bit set: the step direction is negated. The accumulator sign handling is unchanged.
- Simultaneous accept and step on the same edge: acc_next = sat(acc - sign(acc) + delta), where sign(acc) is taken from the pre-update value.
- Outputs: quad_a/quad_b come straight from phase flops, with no combinational path from inputs. Latency is first step at the next step_stb after acceptance (1..STEP_DIV cycles).
- busy: registered, equals (acc_x != 0) || (acc_y != 0) after each update.
- Axes are fully independent; X and Y may step on the same strobe.
- Max output edge rate is one per STEP_DIV clocks per axis.

Optional Feature:
- Macro: TRACKBALL_QUAD_EMU_SAT_EN.
- Defined: accumulator add saturates at max positive / max negative. With ACC_W=10: 500+100 -> 511; -500-100 -> -512.
- Undefined: accumulator add wraps modulo 2^ACC_W (two's complement). 500+100 -> -424; hardware accepts the direction reversal.

Test Plan:
- Reset release: hold rst 3 cycles, release -> quad_a=quad_b=00, busy=0, delta_ready=1 on first post-reset cycle.
- Single +3 X delta (STEP_DIV=16) -> X pins go 01, 11, 10 on three consecutive strobes, 16 clk apart; Y static 00; busy drops after the third step.
- -2 Y delta with DIR_INV=2'b10 -> Y phase advances +1 twice (00->01->11); X unaffected.
- Delta accepted on a step_stb edge: acc_x=5, then +4 arrives at strobe -> acc_x=8 after that edge, one X step emitted.
- Saturation: with macro defined, three deltas of +127, +127, +127 then +127, +127 (acc 635 requested) -> acc_x=511; exactly 511 steps emitted. With macro undefined, same stimulus -> acc_x=-389 and steps run negative.
- Reset mid-operation: +100 X accepted, assert rst after 10 steps -> phase 00, busy=0, no further steps after release.
